slave_mux_n: RTL and testbench

//  Parametrised register-bus router between the SPI register front end and N slave blocks.
//  - Decodes the slave index from the top address bits.
//  - Registers the select, strobes, local address and write data.
//  - Waits for the selected slave's ack and returns its read data with a completion pulse.
//  - Answers unmapped or stalled accesses with DEF_DATA and an error flag.

---
 rtl/slave_mux_n_if.sv | 36 +++
 rtl/slave_mux_n.sv | 170 +++++++++++++++++
 tb/tb_slave_mux_n.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/slave_mux_n_if.sv
// Register-bus bundle for slave_mux_n: front-end request/response side plus the
// N-way slave fan-out. The router uses the slave modport; the driving side uses master.
interface slave_mux_n_if #(
    parameter int N_SLAVES = 4,
    parameter int ADDR_W   = 7,
    parameter int DATA_W   = 8,
    parameter int SEL_W    = 2
);
    logic [ADDR_W-1:0]          i_addr;
    logic [DATA_W-1:0]          i_wr_data;
    logic                       i_wr_stb;
    logic                       i_rd_stb;
    logic                       o_busy;
    logic                       o_done;
    logic                       o_err;
    logic [DATA_W-1:0]          o_rd_data;
    logic [N_SLAVES-1:0]        o_sel;
    logic [ADDR_W-SEL_W-1:0]    o_addr;
    logic [DATA_W-1:0]          o_wr_data;
    logic                       o_wr_stb;
    logic                       o_rd_stb;
    logic [N_SLAVES-1:0]        i_ack;
    logic [N_SLAVES*DATA_W-1:0] i_rd_data;

    modport slave (
        input  i_addr, i_wr_data, i_wr_stb, i_rd_stb, i_ack, i_rd_data,
        output o_busy, o_done, o_err, o_rd_data, o_sel, o_addr, o_wr_data,
        output o_wr_stb, o_rd_stb
    );

    modport master (
        output i_addr, i_wr_data, i_wr_stb, i_rd_stb, i_ack, i_rd_data,
        input  o_busy, o_done, o_err, o_rd_data, o_sel, o_addr, o_wr_data,
        input  o_wr_stb, o_rd_stb
    );
endinterface

// File: rtl/slave_mux_n.sv
// Register-bus router: decodes the slave index from the top address bits, strobes the
// selected slave once and returns its ack/read data. Define SLAVE_MUX_N_TIMEOUT_EN to abort stalled transfers.
module slave_mux_n #(
    parameter int                N_SLAVES = 4,
    parameter int                ADDR_W   = 7,
    parameter int                DATA_W   = 8,
    parameter int                SEL_W    = 2,
    parameter int                TIMEOUT  = 15,
    parameter logic [DATA_W-1:0] DEF_DATA = DATA_W'(8'hFF)
) (
    input  logic         i_clk,
    input  logic         i_reset,
    slave_mux_n_if.slave bus
);
    localparam int LOC_W = ADDR_W - SEL_W;

    typedef enum logic [1:0] {IDLE, XFER, ERR} state_t;

    if ((2 ** SEL_W) < N_SLAVES || TIMEOUT < 1) begin : g_param_check
        $error("slave_mux_n: SEL_W too small for N_SLAVES or TIMEOUT < 1");
    end

    state_t              state_q, state_d;
    logic [N_SLAVES-1:0] sel_q, sel_d;
    logic [SEL_W-1:0]    idx_q, idx_d;
    logic                wr_op_q, wr_op_d;
    logic [LOC_W-1:0]    addr_q, addr_d;
    logic [DATA_W-1:0]   wr_data_q, wr_data_d;
    logic [DATA_W-1:0]   rd_data_q, rd_data_d;
    logic                wr_stb_q, wr_stb_d;
    logic                rd_stb_q, rd_stb_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    logic                ack_sel;
    logic [DATA_W-1:0]   rd_sel;
    logic [SEL_W-1:0]    req_idx;
    logic                req;

`ifdef SLAVE_MUX_N_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    assign req_idx = bus.i_addr[ADDR_W-1 -: SEL_W];
    assign req     = bus.i_wr_stb | bus.i_rd_stb;

    // Only the latched slave's ack and data are visible; all other acks are ignored.
    always_comb begin
        ack_sel = 1'b0;
        rd_sel  = '0;
        for (int k = 0; k < N_SLAVES; k++) begin
            if (idx_q == SEL_W'(k)) begin
                ack_sel = bus.i_ack[k];
                rd_sel  = bus.i_rd_data[k*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        idx_d     = idx_q;
        wr_op_d   = wr_op_q;
        addr_d    = addr_q;
        wr_data_d = wr_data_q;
        rd_data_d = rd_data_q;
        wr_stb_d  = 1'b0;
        rd_stb_d  = 1'b0;
        done_d    = 1'b0;
        err_d     = 1'b0;
`ifdef SLAVE_MUX_N_TIMEOUT_EN
        cnt_d     = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (req) begin
                    idx_d     = req_idx;
                    wr_op_d   = bus.i_wr_stb;
                    addr_d    = bus.i_addr[LOC_W-1:0];
                    wr_data_d = bus.i_wr_data;
`ifdef SLAVE_MUX_N_TIMEOUT_EN
                    cnt_d     = '0;
`endif
                    // A simultaneous read request is dropped in favour of the write.
                    if (int'(req_idx) < N_SLAVES) begin
                        state_d  = XFER;
                        sel_d    = N_SLAVES'(1) << req_idx;
                        wr_stb_d = bus.i_wr_stb;
                        rd_stb_d = ~bus.i_wr_stb;
                    end else begin
                        state_d  = ERR;
                    end
                end
            end
            XFER: begin
`ifdef SLAVE_MUX_N_TIMEOUT_EN
                cnt_d = cnt_q + CNT_W'(1);
`endif
                if (ack_sel) begin
                    state_d = IDLE;
                    sel_d   = '0;
                    done_d  = 1'b1;
                    if (!wr_op_q) rd_data_d = rd_sel;
                end
`ifdef SLAVE_MUX_N_TIMEOUT_EN
                // cnt_q counts XFER cycles already elapsed; an ack in the last one still wins.
                else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d = IDLE;
                    sel_d   = '0;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    if (!wr_op_q) rd_data_d = DEF_DATA;
                end
`endif
            end
            ERR: begin
                state_d = IDLE;
                done_d  = 1'b1;
                err_d   = 1'b1;
                if (!wr_op_q) rd_data_d = DEF_DATA;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q   <= IDLE;
            sel_q     <= '0;
            idx_q     <= '0;
            wr_op_q   <= 1'b0;
            addr_q    <= '0;
            wr_data_q <= '0;
            rd_data_q <= DEF_DATA;
            wr_stb_q  <= 1'b0;
            rd_stb_q  <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
`ifdef SLAVE_MUX_N_TIMEOUT_EN
            cnt_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            idx_q     <= idx_d;
            wr_op_q   <= wr_op_d;
            addr_q    <= addr_d;
            wr_data_q <= wr_data_d;
            rd_data_q <= rd_data_d;
            wr_stb_q  <= wr_stb_d;
            rd_stb_q  <= rd_stb_d;
            done_q    <= done_d;
            err_q     <= err_d;
`ifdef SLAVE_MUX_N_TIMEOUT_EN
            cnt_q     <= cnt_d;
`endif
        end
    end

    assign bus.o_busy    = (state_q != IDLE);
    assign bus.o_done    = done_q;
    assign bus.o_err     = err_q;
    assign bus.o_rd_data = rd_data_q;
    assign bus.o_sel     = sel_q;
    assign bus.o_addr    = addr_q;
    assign bus.o_wr_data = wr_data_q;
    assign bus.o_wr_stb  = wr_stb_q;
    assign bus.o_rd_stb  = rd_stb_q;
endmodule

// File: tb/tb_slave_mux_n.sv
// Bench for slave_mux_n with three slaves (slave index 3 unmapped); a transaction-level
// model predicts completion cycle, error flag, select, strobes and returned data.
module tb_slave_mux_n;
    localparam int N_SLAVES = 3;
    localparam int ADDR_W   = 7;
    localparam int DATA_W   = 8;
    localparam int SEL_W    = 2;
    localparam int TIMEOUT  = 15;
    localparam logic [7:0] DEF_DATA = 8'hFF;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    slave_mux_n_if #(.N_SLAVES(N_SLAVES), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SEL_W(SEL_W)) bus ();

    slave_mux_n #(.N_SLAVES(N_SLAVES), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SEL_W(SEL_W),
                  .TIMEOUT(TIMEOUT), .DEF_DATA(DEF_DATA)) dut (
        .i_clk(clk), .i_reset(rst), .bus(bus));

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] sdata [N_SLAVES];
    logic [7:0] exp_rd;

    always_comb begin
        bus.i_rd_data = '0;
        for (int k = 0; k < N_SLAVES; k++) bus.i_rd_data[k*DATA_W +: DATA_W] = sdata[k];
    end

    // Observations recorded by do_xfer, judged by each test.
    int         obs_done_at;
    logic       obs_err;
    logic [7:0] obs_rd;
    logic [2:0] obs_sel1;
    int         obs_wstb, obs_rstb;
    logic [4:0] obs_addr;
    logic [7:0] obs_wdata;
    bit         obs_sel_stable, obs_sel_clr;

    // Model: completion offset of a transaction given the cycle offset of the slave ack (0 = never).
    function automatic int exp_done_at(input logic [6:0] addr, input int ack_k);
        int idx = int'(addr[6:5]);
        if (idx >= N_SLAVES) return 2;
`ifdef SLAVE_MUX_N_TIMEOUT_EN
        if (ack_k == 0 || ack_k > TIMEOUT) return TIMEOUT + 1;
`endif
        if (ack_k == 0) return 0;
        return ack_k + 1;
    endfunction

    function automatic bit exp_err(input logic [6:0] addr, input int ack_k);
        if (int'(addr[6:5]) >= N_SLAVES) return 1'b1;
`ifdef SLAVE_MUX_N_TIMEOUT_EN
        if (ack_k == 0 || ack_k > TIMEOUT) return 1'b1;
`endif
        return 1'b0;
    endfunction

    function automatic logic [2:0] exp_sel(input logic [6:0] addr);
        int idx = int'(addr[6:5]);
        logic [2:0] s = '0;
        if (idx < N_SLAVES) s[idx] = 1'b1;
        return s;
    endfunction

    // Apply one request at the current cycle T and follow it until o_done or the budget runs out.
    task automatic do_xfer(input logic [6:0] addr, input logic [7:0] wdata, input bit wr,
                           input bit rd, input int ack_k, input bit noise, input int max_c);
        int idx = int'(addr[6:5]);
        logic [2:0] ack;
        bus.i_addr = addr; bus.i_wr_data = wdata; bus.i_wr_stb = wr; bus.i_rd_stb = rd;
        obs_done_at = 0; obs_err = 1'bx; obs_rd = 'x; obs_sel1 = 'x;
        obs_wstb = 0; obs_rstb = 0; obs_sel_stable = 1'b1; obs_sel_clr = 1'b0;
        @(posedge clk); #1;
        bus.i_wr_stb = 1'b0; bus.i_rd_stb = 1'b0;
        bus.i_addr = 7'($urandom); bus.i_wr_data = 8'($urandom);
        for (int c = 1; c <= max_c; c++) begin
            if (c == 1) begin
                obs_sel1 = bus.o_sel; obs_addr = bus.o_addr; obs_wdata = bus.o_wr_data;
            end
            obs_wstb += int'(bus.o_wr_stb);
            obs_rstb += int'(bus.o_rd_stb);
            if (bus.o_done) begin
                obs_done_at = c; obs_err = bus.o_err; obs_rd = bus.o_rd_data;
                obs_sel_clr = (bus.o_sel == 3'b000);
                break;
            end
            if (bus.o_sel !== obs_sel1) obs_sel_stable = 1'b0;
            ack = noise ? 3'($urandom) : 3'b000;
            if (idx < N_SLAVES) ack[idx] = (c == ack_k);
            bus.i_ack = ack;
            @(posedge clk); #1;
        end
        bus.i_ack = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.i_addr = '0; bus.i_wr_data = '0; bus.i_wr_stb = 1'b0; bus.i_rd_stb = 1'b0;
        bus.i_ack = '0;
        for (int k = 0; k < N_SLAVES; k++) sdata[k] = '0;
        repeat (2) @(posedge clk);
        #1;
        n_vec++; if (bus.o_sel !== 3'b000) begin n_err++; $display("FAIL reset_sel got %b want 000", bus.o_sel); end
        n_vec++; if ({bus.o_wr_stb, bus.o_rd_stb, bus.o_done, bus.o_err, bus.o_busy} !== 5'b0) begin
            n_err++; $display("FAIL reset_ctrl got %b want 00000", {bus.o_wr_stb, bus.o_rd_stb, bus.o_done, bus.o_err, bus.o_busy}); end
        n_vec++; if (bus.o_rd_data !== DEF_DATA) begin n_err++; $display("FAIL reset_rd_data got %h want %h", bus.o_rd_data, DEF_DATA); end
        n_vec++; if ({bus.o_addr, bus.o_wr_data} !== 13'b0) begin
            n_err++; $display("FAIL reset_addr_wdata got %h/%h want 0/0", bus.o_addr, bus.o_wr_data); end
        rst = 1'b0;
        exp_rd = DEF_DATA;
    endtask

    task automatic test_read_basic();
        sdata[1] = 8'hA5;
        do_xfer(7'h25, 8'h00, 1'b0, 1'b1, 1, 1'b0, 30);
        n_vec++; if (obs_sel1 !== 3'b010) begin n_err++; $display("FAIL rd_sel got %b want 010", obs_sel1); end
        n_vec++; if (obs_rstb !== 1 || obs_wstb !== 0) begin n_err++; $display("FAIL rd_strobes got rd=%0d wr=%0d want rd=1 wr=0", obs_rstb, obs_wstb); end
        n_vec++; if (obs_addr !== 5'h05) begin n_err++; $display("FAIL rd_addr got %h want 05", obs_addr); end
        n_vec++; if (obs_done_at !== 2) begin n_err++; $display("FAIL rd_latency got %0d want 2", obs_done_at); end
        n_vec++; if (obs_err !== 1'b0 || obs_rd !== 8'hA5) begin n_err++; $display("FAIL rd_result got err=%b data=%h want err=0 data=a5", obs_err, obs_rd); end
        exp_rd = 8'hA5;
    endtask

    task automatic test_write_basic();
        sdata[2] = 8'h77;
        do_xfer(7'h41, 8'h3C, 1'b1, 1'b0, 4, 1'b0, 30);
        n_vec++; if (obs_sel1 !== 3'b100) begin n_err++; $display("FAIL wr_sel got %b want 100", obs_sel1); end
        n_vec++; if (obs_wstb !== 1 || obs_rstb !== 0) begin n_err++; $display("FAIL wr_strobes got wr=%0d rd=%0d want wr=1 rd=0", obs_wstb, obs_rstb); end
        n_vec++; if (obs_wdata !== 8'h3C || obs_addr !== 5'h01) begin n_err++; $display("FAIL wr_data got %h@%h want 3c@01", obs_wdata, obs_addr); end
        n_vec++; if (obs_done_at !== 5 || obs_err !== 1'b0) begin n_err++; $display("FAIL wr_done got at=%0d err=%b want at=5 err=0", obs_done_at, obs_err); end
        n_vec++; if (obs_rd !== exp_rd) begin n_err++; $display("FAIL wr_rd_kept got %h want %h", obs_rd, exp_rd); end
    endtask

    task automatic test_unmapped();
        do_xfer(7'h7F, 8'h12, 1'b1, 1'b0, 0, 1'b1, 30);
        n_vec++; if (obs_done_at !== 2 || obs_err !== 1'b1) begin n_err++; $display("FAIL unmap_wr got at=%0d err=%b want at=2 err=1", obs_done_at, obs_err); end
        n_vec++; if (obs_rd !== exp_rd) begin n_err++; $display("FAIL unmap_wr_rd got %h want %h", obs_rd, exp_rd); end
        do_xfer(7'h60, 8'h00, 1'b0, 1'b1, 0, 1'b0, 30);
        n_vec++; if (obs_sel1 !== 3'b000 || obs_wstb !== 0 || obs_rstb !== 0) begin
            n_err++; $display("FAIL unmap_quiet got sel=%b wr=%0d rd=%0d want 000/0/0", obs_sel1, obs_wstb, obs_rstb); end
        n_vec++; if (obs_done_at !== 2 || obs_err !== 1'b1 || obs_rd !== DEF_DATA) begin
            n_err++; $display("FAIL unmap_rd got at=%0d err=%b data=%h want at=2 err=1 data=ff", obs_done_at, obs_err, obs_rd); end
        exp_rd = DEF_DATA;
    endtask

    task automatic test_both_strobes();
        sdata[0] = 8'h5A;
        do_xfer(7'h0B, 8'hC3, 1'b1, 1'b1, 2, 1'b0, 30);
        n_vec++; if (obs_wstb !== 1 || obs_rstb !== 0) begin n_err++; $display("FAIL both_strobes got wr=%0d rd=%0d want wr=1 rd=0", obs_wstb, obs_rstb); end
        n_vec++; if (obs_done_at !== 3 || obs_rd !== exp_rd) begin
            n_err++; $display("FAIL both_done got at=%0d data=%h want at=3 data=%h", obs_done_at, obs_rd, exp_rd); end
    endtask

    task automatic test_random();
        for (int t = 0; t < 40; t++) begin
            logic [6:0] addr = 7'($urandom);
            logic [7:0] wd   = 8'($urandom);
            int sel          = $urandom_range(0, 2);
            bit wr           = (sel != 0);
            bit rd           = (sel != 1);
            int ack_k        = $urandom_range(1, 6);
            int gap          = $urandom_range(0, 2);
            int want_at;
            bit want_err;
            for (int k = 0; k < N_SLAVES; k++) sdata[k] = 8'($urandom);
            for (int g = 0; g < gap; g++) begin
                bus.i_ack = 3'($urandom);
                @(posedge clk); #1;
                n_vec++; if (bus.o_done !== 1'b0 || bus.o_busy !== 1'b0) begin
                    n_err++; $display("FAIL idle_ack got done=%b busy=%b want 0/0", bus.o_done, bus.o_busy); end
            end
            bus.i_ack = '0;
            want_at  = exp_done_at(addr, ack_k);
            want_err = exp_err(addr, ack_k);
            do_xfer(addr, wd, wr, rd, ack_k, 1'b1, 30);
            if (!wr) exp_rd = want_err ? DEF_DATA : sdata[addr[6:5]];
            n_vec++; if (obs_done_at !== want_at || obs_err !== want_err) begin
                n_err++; $display("FAIL rnd_done addr=%h got at=%0d err=%b want at=%0d err=%b", addr, obs_done_at, obs_err, want_at, want_err); end
            n_vec++; if (obs_rd !== exp_rd) begin n_err++; $display("FAIL rnd_rd_data addr=%h got %h want %h", addr, obs_rd, exp_rd); end
            n_vec++; if (obs_sel1 !== exp_sel(addr) || !obs_sel_stable || !obs_sel_clr) begin
                n_err++; $display("FAIL rnd_sel addr=%h got %b stable=%b clr=%b want %b 1 1", addr, obs_sel1, obs_sel_stable, obs_sel_clr, exp_sel(addr)); end
            n_vec++; if (obs_wstb !== int'(wr && exp_sel(addr) != 0) || obs_rstb !== int'(!wr && exp_sel(addr) != 0)) begin
                n_err++; $display("FAIL rnd_strobes addr=%h got wr=%0d rd=%0d", addr, obs_wstb, obs_rstb); end
            n_vec++; if (obs_addr !== addr[4:0] || obs_wdata !== wd) begin
                n_err++; $display("FAIL rnd_latch got %h/%h want %h/%h", obs_addr, obs_wdata, addr[4:0], wd); end
        end
    endtask

`ifdef SLAVE_MUX_N_TIMEOUT_EN
    task automatic test_timeout();
        sdata[0] = 8'h96;
        do_xfer(7'h05, 8'h00, 1'b0, 1'b1, 0, 1'b1, 40);
        n_vec++; if (obs_done_at !== TIMEOUT + 1 || obs_err !== 1'b1 || obs_rd !== DEF_DATA) begin
            n_err++; $display("FAIL timeout_rd got at=%0d err=%b data=%h want at=%0d err=1 data=ff", obs_done_at, obs_err, obs_rd, TIMEOUT + 1); end
        do_xfer(7'h05, 8'h00, 1'b0, 1'b1, TIMEOUT, 1'b1, 40);
        n_vec++; if (obs_done_at !== TIMEOUT + 1 || obs_err !== 1'b0 || obs_rd !== 8'h96) begin
            n_err++; $display("FAIL timeout_late_ack got at=%0d err=%b data=%h want at=%0d err=0 data=96", obs_done_at, obs_err, obs_rd, TIMEOUT + 1); end
        exp_rd = 8'h96;
        do_xfer(7'h30, 8'h11, 1'b1, 1'b0, 0, 1'b0, 40);
        n_vec++; if (obs_done_at !== TIMEOUT + 1 || obs_err !== 1'b1 || obs_rd !== exp_rd) begin
            n_err++; $display("FAIL timeout_wr got at=%0d err=%b data=%h want err=1 data=%h", obs_done_at, obs_err, obs_rd, exp_rd); end
    endtask
`else
    task automatic test_stall();
        do_xfer(7'h22, 8'h00, 1'b0, 1'b1, 0, 1'b1, 40);
        n_vec++; if (obs_done_at !== 0 || bus.o_busy !== 1'b1) begin
            n_err++; $display("FAIL stall got done_at=%0d busy=%b want 0/1", obs_done_at, bus.o_busy); end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_rd = DEF_DATA;
        n_vec++; if (bus.o_busy !== 1'b0 || bus.o_sel !== 3'b000) begin
            n_err++; $display("FAIL stall_reset got busy=%b sel=%b want 0/000", bus.o_busy, bus.o_sel); end
    endtask
`endif

    task automatic test_back_to_back();
        sdata[0] = 8'h4E; sdata[1] = 8'hD2; sdata[2] = 8'hEE;
        bus.i_addr = 7'h2A; bus.i_rd_stb = 1'b1;
        @(posedge clk); #1;
        n_vec++; if (bus.o_sel !== 3'b010 || bus.o_rd_stb !== 1'b1) begin
            n_err++; $display("FAIL b2b_first_sel got %b stb=%b want 010 1", bus.o_sel, bus.o_rd_stb); end
        bus.i_ack = 3'b010; bus.i_addr = 7'h07;
        @(posedge clk); #1;
        bus.i_ack = '0;
        n_vec++; if (bus.o_done !== 1'b1 || bus.o_err !== 1'b0 || bus.o_rd_data !== 8'hD2 || bus.o_sel !== 3'b000 || bus.o_rd_stb !== 1'b0) begin
            n_err++; $display("FAIL b2b_first_done got done=%b err=%b data=%h sel=%b stb=%b want 1 0 d2 000 0",
                              bus.o_done, bus.o_err, bus.o_rd_data, bus.o_sel, bus.o_rd_stb); end
        @(posedge clk); #1;
        bus.i_rd_stb = 1'b0;
        n_vec++; if (bus.o_sel !== 3'b001 || bus.o_rd_stb !== 1'b1 || bus.o_addr !== 5'h07 || bus.o_done !== 1'b0) begin
            n_err++; $display("FAIL b2b_second_accept got sel=%b stb=%b addr=%h done=%b want 001 1 07 0",
                              bus.o_sel, bus.o_rd_stb, bus.o_addr, bus.o_done); end
        bus.i_ack = 3'b101;
        @(posedge clk); #1;
        bus.i_ack = '0;
        n_vec++; if (bus.o_done !== 1'b1 || bus.o_err !== 1'b0 || bus.o_rd_data !== 8'h4E) begin
            n_err++; $display("FAIL b2b_spurious got done=%b err=%b data=%h want 1 0 4e", bus.o_done, bus.o_err, bus.o_rd_data); end
        exp_rd = 8'h4E;
    endtask

    task automatic test_reset_mid();
        sdata[2] = 8'h3D;
        bus.i_addr = 7'h45; bus.i_rd_stb = 1'b1;
        @(posedge clk); #1;
        bus.i_rd_stb = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_vec++; if ({bus.o_sel, bus.o_wr_stb, bus.o_rd_stb, bus.o_done, bus.o_err, bus.o_busy} !== 8'b0) begin
            n_err++; $display("FAIL midreset_ctrl got sel=%b stb=%b%b done=%b err=%b busy=%b want all 0",
                              bus.o_sel, bus.o_wr_stb, bus.o_rd_stb, bus.o_done, bus.o_err, bus.o_busy); end
        n_vec++; if (bus.o_rd_data !== DEF_DATA || bus.o_addr !== 5'h00 || bus.o_wr_data !== 8'h00) begin
            n_err++; $display("FAIL midreset_data got rd=%h addr=%h wd=%h want ff 00 00", bus.o_rd_data, bus.o_addr, bus.o_wr_data); end
        @(posedge clk); #1;
        n_vec++; if (bus.o_done !== 1'b0) begin n_err++; $display("FAIL midreset_no_done got %b want 0", bus.o_done); end
        do_xfer(7'h45, 8'h00, 1'b0, 1'b1, 2, 1'b1, 30);
        n_vec++; if (obs_done_at !== 3 || obs_err !== 1'b0 || obs_rd !== 8'h3D) begin
            n_err++; $display("FAIL midreset_recover got at=%0d err=%b data=%h want 3 0 3d", obs_done_at, obs_err, obs_rd); end
        exp_rd = 8'h3D;
    endtask

    initial begin
        test_reset();
        test_read_basic();
        test_write_basic();
        test_unmapped();
        test_both_strobes();
        test_back_to_back();
        test_random();
`ifdef SLAVE_MUX_N_TIMEOUT_EN
        test_timeout();
`else
        test_stall();
`endif
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
